// File: rtl/arith_unit_if.sv
// rtl/arith_unit_if.sv - operand/result handshake bundle for arith_unit
interface arith_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] i_a;
    logic [DATA_WIDTH-1:0] i_b;
    logic [1:0]            i_op;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_is_neg;
    logic                  o_error;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output i_a, i_b, i_op, i_valid, i_ready,
        input  o_ready, o_data, o_data_is_neg, o_error, o_valid
    );

    modport slave (
        input  i_a, i_b, i_op, i_valid, i_ready,
        output o_ready, o_data, o_data_is_neg, o_error, o_valid
    );
endinterface

// File: rtl/arith_unit.sv
// rtl/arith_unit.sv - signed add/sub/mul/div unit with sign-magnitude result
module arith_unit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    arith_unit_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [2*DW-1:0] MAX_POS = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW-1:0] MAX_NEG = MAX_POS + 1'b1;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

    if ((DATA_WIDTH < 4) || (DATA_WIDTH % 4 != 0)) begin : g_bad_width
        $fatal(1, "arith_unit: DATA_WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_COMPUTE = 2'b01, S_OUTPUT = 2'b10} state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_a, r_b;
    logic [1:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_acc;
    logic [DW-1:0]   r_data;
    logic            r_neg, r_err;

    logic [DW-1:0]   w_mag_a, w_mag_b, w_rem_nxt;
    logic [DW:0]     w_trial, w_sum, w_sum_mag;
    logic            w_ge;
    logic [2*DW-1:0] w_acc_nxt, w_mag;
    logic            w_neg_raw, w_neg, w_err;

    assign w_mag_a = r_a[DW-1] ? -r_a : r_a;
    assign w_mag_b = r_b[DW-1] ? -r_b : r_b;
    assign w_sum   = (r_op == OP_SUB) ? ({r_a[DW-1], r_a} - {r_b[DW-1], r_b})
                                      : ({r_a[DW-1], r_a} + {r_b[DW-1], r_b});

    // r_acc is the product for multiply, {remainder, quotient} for divide
    always_comb begin
        w_trial   = {r_acc[2*DW-1:DW], w_mag_a[r_cnt]};
        w_ge      = (w_trial >= {1'b0, w_mag_b});
        w_rem_nxt = w_ge ? (w_trial[DW-1:0] - w_mag_b) : w_trial[DW-1:0];
        if (r_op == OP_MUL)
            w_acc_nxt = {r_acc[2*DW-2:0], 1'b0} + (w_mag_b[r_cnt] ? {{DW{1'b0}}, w_mag_a} : '0);
        else
            w_acc_nxt = {w_rem_nxt, r_acc[DW-2:0], w_ge};
    end

    always_comb begin
        w_sum_mag = w_sum[DW] ? -w_sum : w_sum;
        w_mag     = {{(DW-1){1'b0}}, w_sum_mag};
        w_neg_raw = w_sum[DW];
        if (r_op == OP_MUL) begin
            w_mag     = w_acc_nxt;
            w_neg_raw = r_a[DW-1] ^ r_b[DW-1];
        end else if (r_op == OP_DIV) begin
            w_mag     = {{DW{1'b0}}, w_acc_nxt[DW-1:0]};
            w_neg_raw = r_a[DW-1] ^ r_b[DW-1];
        end
        w_neg = w_neg_raw && (w_mag != '0);
        w_err = (w_neg ? (w_mag > MAX_NEG) : (w_mag > MAX_POS))
                || ((r_op == OP_DIV) && (r_b == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.i_valid) w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (r_cnt == '0) w_state_nxt = S_OUTPUT;
            S_OUTPUT:  if (bus.i_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= OP_ADD;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_data <= '0;
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (bus.i_valid) begin
                r_a   <= bus.i_a;
                r_b   <= bus.i_b;
                r_op  <= bus.i_op;
                r_acc <= '0;
                r_cnt <= bus.i_op[1] ? CW'(DW - 1) : '0;
            end
        end else if (r_state == S_COMPUTE) begin
            r_acc <= w_acc_nxt;
            if (r_cnt == '0) begin
                r_data <= w_err ? '0 : w_mag[DW-1:0];
                r_neg  <= w_neg && !w_err;
                r_err  <= w_err;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign bus.o_ready       = (r_state == S_IDLE);
    assign bus.o_valid       = (r_state == S_OUTPUT);
    assign bus.o_data        = r_data;
    assign bus.o_data_is_neg = r_neg;
    assign bus.o_error       = r_err;
endmodule

// File: doc/arith_unit.md
ARITH_UNIT -- requirements
Module: arith_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand/result width in bits; must be a multiple of 4 and at least 4, otherwise elaboration fails fatally.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_a  input  DATA_WIDTH  operand A, two's complement.
REQ-005 SHALL have port i_b  input  DATA_WIDTH  operand B, two's complement.
REQ-006 SHALL have port i_op  input  2  operation: 00 add, 01 subtract (A-B), 10 multiply, 11 divide (A/B).
REQ-007 SHALL have port i_valid  input  1  operands and operation are valid.
REQ-008 SHALL have port o_ready  output  1  block can accept operands; high only in IDLE.
REQ-009 SHALL have port o_data  output  DATA_WIDTH  unsigned magnitude of the result.
REQ-010 SHALL have port o_data_is_neg  output  1  result is strictly negative.
REQ-011 SHALL have port o_error  output  1  overflow or divide-by-zero.
REQ-012 SHALL have port o_valid  output  1  result outputs are valid.
REQ-013 SHALL have port i_ready  input  1  downstream (display driver) accepts the result.

Function
REQ-014 SHALL implement states IDLE, COMPUTE, OUTPUT; an unencoded state SHALL return to IDLE on the next edge.
REQ-015 SHALL accept input on an edge where i_valid && o_ready; it SHALL register i_a, i_b, i_op and enter COMPUTE.
REQ-016 SHALL spend exactly 1 cycle in COMPUTE for add/subtract and exactly DATA_WIDTH cycles for multiply/divide, using a down-counter of width clog2(DATA_WIDTH).
REQ-017 SHALL implement multiply as an iterative shift-add of operand magnitudes, one bit per cycle, into a 2*DATA_WIDTH-bit product.
REQ-018 SHALL implement divide as an iterative restoring divide of magnitudes, one quotient bit per cycle; quotient truncates toward zero and the remainder is discarded.
REQ-019 SHALL compute the result sign as sign(A) XOR sign(B) for multiply/divide, and from the full-precision sum for add/subtract.
REQ-020 SHALL flag o_error when the signed result lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], including add/subtract overflow, multiply overflow, and most-negative / -1.
REQ-021 SHALL flag o_error for divide with B == 0; the iterative divide SHALL still take DATA_WIDTH cycles.
REQ-022 SHALL, when o_error is high, drive o_data = 0 and o_data_is_neg = 0.
REQ-023 SHALL drive o_data_is_neg = 0 for a zero result (no negative zero), e.g. -5 * 0.
REQ-024 SHALL represent a result of -2^(DATA_WIDTH-1) as o_data = 2^(DATA_WIDTH-1), o_data_is_neg = 1, o_error = 0.
REQ-025 SHALL load the registered result outputs and enter OUTPUT on the last COMPUTE edge; o_valid = 1 exactly while in OUTPUT.
REQ-026 SHALL hold o_data, o_data_is_neg and o_error stable while o_valid && !i_ready, for any number of cycles.
REQ-027 SHALL return to IDLE on the edge where o_valid && i_ready; o_ready rises in the following cycle, with no same-cycle re-acceptance.
REQ-028 SHALL ignore i_valid and changes on i_a, i_b, i_op outside IDLE.

Reset
REQ-029 SHALL, while rst_n is low, immediately force state IDLE, o_valid = 0, o_data = 0, o_data_is_neg = 0, o_error = 0, counter = 0 and internal operands = 0; o_ready = 1 after reset.
REQ-030 SHALL abandon any in-progress computation or pending result on reset assertion, with no o_valid pulse afterwards for the aborted operation.

Verification
REQ-031 SHALL pass this directed scenario: add 0x7FFF + 0x0001 -> one cycle after accept, o_valid = 1, o_error = 1, o_data = 0x0000, o_data_is_neg = 0.
REQ-032 SHALL pass this directed scenario: sub 5 - 12 -> o_data = 0x0007, o_data_is_neg = 1, o_error = 0, o_valid 1 cycle after accept.
REQ-033 SHALL pass this directed scenario: mul -300 * 100 -> exactly 16 cycles after accept, o_data = 0x7530, o_data_is_neg = 1; mul 0x0100 * 0x0100 -> o_error = 1.
REQ-034 SHALL pass this directed scenario: div -7 / 2 -> o_data = 0x0003, o_data_is_neg = 1; div 9 / 0 -> o_error = 1 after 16 cycles; div 0x8000 / 0xFFFF -> o_error = 1.
REQ-035 SHALL pass this directed scenario: result pending with i_ready held low for 10 cycles -> outputs stable, o_ready = 0, i_valid pulses ignored; i_ready = 1 -> IDLE next edge, then o_ready = 1.
REQ-036 SHALL pass this directed scenario: rst_n asserted 5 cycles into a multiply -> outputs return to reset values at once; after release, a new add 1 + 1 yields o_data = 0x0002, o_data_is_neg = 0.
